// File: rtl/serial_sum_pkg.sv
// Shared types and sizing for the serial sum collector slice.
package serial_sum_pkg;

    // Default number of sum bits per word.
    localparam int WIDTH_DEF = 8;

    // Bit counter width: it must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/sum_sipo.sv
// WIDTH-bit indexed-load register: assembles the serial sum bits of one word.
// A 'first' load starts a fresh word, so the bits of any earlier word are zeroed.
module sum_sipo
    import serial_sum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = cnt_width(WIDTH_DEF)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ld,
    input  logic             first,
    input  logic [IDX_W-1:0] idx,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    // Clear, start a new word at bit 0, or store one bit at the index given.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (ld) begin
            if (first) begin
                q    <= '0;
                q[0] <= d;
            end else begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (idx == IDX_W'(i)) begin
                        q[i] <= d;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/serial_sum_collector.sv
// Deserialises the bit-level adder's sum stream (LSB first) into WIDTH-bit
// words, captures the carry of the last bit, and offers each word on a
// valid/ready output. Framing errors and overruns are reported as sticky flags.
//
// Output handshake: word_valid is a registered signal that is high exactly
// while a completed word is held. It never depends on word_ready in the same
// cycle. A word transfers on any rising edge where word_valid and word_ready
// are both high. word_out and carry_out do not change while word_valid is high
// and no transfer has taken place.
module serial_sum_collector
    import serial_sum_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             s_in,
    input  logic             q_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] word_out,
    output logic             carry_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             framing_err,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] count_n;
    logic             ld, first, carry_ld, set_fe, set_ov, xfer;

    assign xfer = word_valid & word_ready;
    assign busy = (state != IDLE);

    sum_sipo #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_sipo (
        .clk   (clk),
        .clr   (reset),
        .ld    (ld),
        .first (first),
        .idx   (bit_count),
        .d     (s_in),
        .q     (word_out)
    );

    // Next-state, bit counter and load strobes. s_in/q_in are only consumed
    // under bit_valid, so junk on them in idle cycles never reaches a register.
    always_comb begin
        state_n  = state;
        count_n  = bit_count;
        ld       = 1'b0;
        first    = 1'b0;
        carry_ld = 1'b0;
        set_fe   = 1'b0;
        set_ov   = 1'b0;
        case (state)
            IDLE: begin
                if (bit_valid) begin
                    if (frame_start) begin
                        ld      = 1'b1;
                        first   = 1'b1;
                        count_n = ONE;
                        if (WIDTH == 1) begin
                            carry_ld = 1'b1;
                            state_n  = HOLD;
                        end else begin
                            state_n  = COLLECT;
                        end
                    end else begin
                        set_fe = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (bit_valid) begin
                    ld = 1'b1;
                    if (frame_start) begin
                        // Restart: the partial word is thrown away.
                        first   = 1'b1;
                        count_n = ONE;
                        set_fe  = 1'b1;
                    end else begin
                        count_n = bit_count + ONE;
                        if (bit_count == LAST_IDX) begin
                            carry_ld = 1'b1;
                            state_n  = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (xfer) begin
                    if (bit_valid && frame_start) begin
                        // Next word starts in the transfer cycle: no bubble.
                        ld      = 1'b1;
                        first   = 1'b1;
                        count_n = ONE;
                        if (WIDTH == 1) begin
                            carry_ld = 1'b1;
                            state_n  = HOLD;
                        end else begin
                            state_n  = COLLECT;
                        end
                    end else begin
                        // A stray non-start bit here is treated like one seen in IDLE.
                        set_fe  = bit_valid;
                        count_n = '0;
                        state_n = IDLE;
                    end
                end else if (bit_valid) begin
                    set_ov = 1'b1;
                end
            end
            default: begin
                count_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    // State, counter, carry, registered word_valid and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_count   <= '0;
            carry_out   <= 1'b0;
            word_valid  <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state      <= state_n;
            bit_count  <= count_n;
            word_valid <= (state_n == HOLD);
            if (carry_ld) begin
                carry_out <= q_in;
            end
            if (set_fe) begin
                framing_err <= 1'b1;
            end else if (clr_err) begin
                framing_err <= 1'b0;
            end
            if (set_ov) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_sum_collector.sv
// Bench for serial_sum_collector with WIDTH=8: inputs change on the falling
// edge, outputs are checked just after the rising edge, and delivered words
// are compared against a queue of expected {carry, word} values.
module tb_serial_sum_collector;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          bit_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic          s_in = 1'b0;
    logic          q_in = 1'b0;
    logic          clr_err = 1'b0;
    logic          word_ready = 1'b0;
    logic [W-1:0]  word_out;
    logic          carry_out;
    logic          word_valid;
    logic          busy;
    logic [CW-1:0] bit_count;
    logic          framing_err;
    logic          overrun;

    logic [W:0]    exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            last_xfer = 0;
    int            prev_xfer = 0;

    serial_sum_collector #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .s_in        (s_in),
        .q_in        (q_in),
        .clr_err     (clr_err),
        .word_out    (word_out),
        .carry_out   (carry_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .busy        (busy),
        .bit_count   (bit_count),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: one cycle's handshake sampled just before the rising edge.
    always begin
        logic [W:0] exp;
        @(negedge clk);
        #4;
        if (!reset && word_valid && word_ready) begin
            n_vec++;
            prev_xfer = last_xfer;
            last_xfer = cyc;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL xfer_unexpected got=%h want=none", {carry_out, word_out});
            end else begin
                exp = exp_q.pop_front();
                if ({carry_out, word_out} !== exp) begin
                    n_err++;
                    $display("FAIL xfer_word got=%h want=%h", {carry_out, word_out}, exp);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // Driver tasks.
    task automatic drive(input logic bv, input logic fs, input logic s, input logic q);
        @(negedge clk);
        bit_valid   = bv;
        frame_start = fs;
        s_in        = bv ? s : 1'($urandom_range(0, 1));
        q_in        = bv ? q : 1'($urandom_range(0, 1));
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic c);
        for (int i = 0; i < W; i++) begin
            drive(1'b1, i == 0, w[i], (i == W - 1) ? c : 1'($urandom_range(0, 1)));
        end
        exp_q.push_back({c, w});
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_word_valid got=%b want=0", word_valid); end
        n_vec++; if (word_out !== 8'h00) begin n_err++; $display("FAIL reset_word_out got=%h want=00", word_out); end
        n_vec++; if (carry_out !== 1'b0) begin n_err++; $display("FAIL reset_carry got=%b want=0", carry_out); end
        n_vec++; if (bit_count !== 4'd0) begin n_err++; $display("FAIL reset_bit_count got=%0d want=0", bit_count); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_vec++; if ({framing_err, overrun} !== 2'b00) begin n_err++; $display("FAIL reset_errs got=%b want=00", {framing_err, overrun}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] w;
        w = 8'hA5;
        word_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            drive(1'b1, i == 0, w[i], (i == W - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
            if (i == W - 1) exp_q.push_back({1'b1, w});
            @(posedge clk);
            #1;
            n_vec++; if (bit_count !== CW'(i + 1)) begin n_err++; $display("FAIL basic_count got=%0d want=%0d", bit_count, i + 1); end
            if (i < W - 1) begin
                n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got=%b want=0", word_valid); end
            end
        end
        n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b want=1", word_valid); end
        n_vec++; if (word_out !== 8'hA5) begin n_err++; $display("FAIL basic_word got=%h want=a5", word_out); end
        n_vec++; if (carry_out !== 1'b1) begin n_err++; $display("FAIL basic_carry got=%b want=1", carry_out); end
        idle();
        @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
        n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL basic_idle_valid got=%b want=0", word_valid); end
        n_vec++; if (bit_count !== 4'd0) begin n_err++; $display("FAIL basic_idle_count got=%0d want=0", bit_count); end
    endtask

    task automatic test_backpressure();
        word_ready = 1'b0;
        send_word(8'h3C, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else idle();
            @(posedge clk);
            #1;
            n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got=%b want=1", word_valid); end
            n_vec++; if ({carry_out, word_out} !== 9'h03C) begin n_err++; $display("FAIL bp_hold got=%h want=03c", {carry_out, word_out}); end
        end
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL bp_overrun got=%b want=1", overrun); end
        n_vec++; if (framing_err !== 1'b0) begin n_err++; $display("FAIL bp_framing got=%b want=0", framing_err); end
        word_ready = 1'b1;
        idle();
        @(posedge clk);
        #1;
        n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got=%b want=0", word_valid); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_pending got=%0d want=0", exp_q.size()); end
        clr_err = 1'b1;
        idle();
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_clr got=%b want=0", overrun); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        w = 8'h01;
        word_ready = 1'b1;
        send_word(8'hFF, 1'b1);
        drive(1'b1, 1'b1, w[0], 1'($urandom_range(0, 1)));
        @(posedge clk);
        #1;
        n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid got=%b want=0", word_valid); end
        n_vec++; if (bit_count !== 4'd1) begin n_err++; $display("FAIL b2b_count got=%0d want=1", bit_count); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy got=%b want=1", busy); end
        for (int i = 1; i < W; i++) begin
            drive(1'b1, 1'b0, w[i], (i == W - 1) ? 1'b0 : 1'($urandom_range(0, 1)));
        end
        exp_q.push_back({1'b0, w});
        @(posedge clk);
        #1;
        n_vec++; if ({carry_out, word_out} !== 9'h001) begin n_err++; $display("FAIL b2b_word got=%h want=001", {carry_out, word_out}); end
        idle();
        @(posedge clk);
        #1;
        n_vec++; if (last_xfer - prev_xfer != W) begin n_err++; $display("FAIL b2b_gap got=%0d want=%0d", last_xfer - prev_xfer, W); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_pending got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_framing();
        word_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'h5A, 1'b1);
        @(posedge clk);
        #1;
        n_vec++; if (framing_err !== 1'b1) begin n_err++; $display("FAIL frame_err got=%b want=1", framing_err); end
        n_vec++; if ({carry_out, word_out} !== 9'h15A) begin n_err++; $display("FAIL frame_word got=%h want=15a", {carry_out, word_out}); end
        clr_err = 1'b1;
        idle();
        @(posedge clk);
        #1;
        n_vec++; if (framing_err !== 1'b0) begin n_err++; $display("FAIL frame_clr got=%b want=0", framing_err); end
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        n_vec++; if (framing_err !== 1'b1) begin n_err++; $display("FAIL frame_idle_set got=%b want=1", framing_err); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL frame_idle_busy got=%b want=0", busy); end
        idle();
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        n_vec++; if (framing_err !== 1'b0) begin n_err++; $display("FAIL frame_clr2 got=%b want=0", framing_err); end
    endtask

    task automatic test_reset_mid();
        word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, 1'b1, 1'b1);
        end
        @(posedge clk);
        #1;
        n_vec++; if (bit_count !== 4'd4) begin n_err++; $display("FAIL rmid_count got=%0d want=4", bit_count); end
        @(negedge clk);
        reset     = 1'b1;
        bit_valid = 1'b0;
        @(posedge clk);
        #1;
        n_vec++; if ({busy, word_valid} !== 2'b00) begin n_err++; $display("FAIL rmid_state got=%b want=00", {busy, word_valid}); end
        n_vec++; if (word_out !== 8'h00) begin n_err++; $display("FAIL rmid_word got=%h want=00", word_out); end
        n_vec++; if (bit_count !== 4'd0) begin n_err++; $display("FAIL rmid_count0 got=%0d want=0", bit_count); end
        @(negedge clk);
        reset = 1'b0;
        send_word(8'h81, 1'b0);
        @(posedge clk);
        #1;
        n_vec++; if ({carry_out, word_out} !== 9'h081) begin n_err++; $display("FAIL rmid_word2 got=%h want=081", {carry_out, word_out}); end
        idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_framing();
        test_reset_mid();
        repeat (2) idle();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL final_pending got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
